// File: rtl/fetch_btb_unit.sv
// Fetch stage: PC register plus direct-mapped BTB with 2-bit counters.
// Resolves Execute outcomes into redirects and keeps branch statistics.
module fetch_btb_unit #(
   parameter int XLEN = 32,
   parameter int BTB_ENTRIES = 16,
   parameter int IADDR_W = 6,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int CNT_W = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_f,
   input  logic ex_valid,
   input  logic ex_is_cf,
   input  logic [XLEN-1:0] ex_pc,
   input  logic ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic [XLEN-1:0] pc_f,
   output logic [XLEN-1:0] pc_next,
   output logic [IADDR_W-1:0] imem_addr,
   output logic pred_taken_f,
   output logic [XLEN-1:0] pred_target_f,
   output logic redirect,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0] btb_tag [BTB_ENTRIES];
   logic [XLEN-1:0] btb_target [BTB_ENTRIES];
   logic [1:0] btb_ctr [BTB_ENTRIES];

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic f_hit;
   logic [XLEN-1:0] pc_plus4;

   logic [IDX_W-1:0] e_idx;
   logic [TAG_W-1:0] e_tag;
   logic e_hit;
   logic upd;
   logic [XLEN-1:0] redirect_pc;
   logic [1:0] ctr_new;

   assign f_idx = pc_f[IDX_W+1:2];
   assign f_tag = pc_f[XLEN-1:IDX_W+2];
   assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
   assign pc_plus4 = pc_f + XLEN'(4);

   assign pred_taken_f = f_hit && btb_ctr[f_idx][1];
   assign pred_target_f = f_hit ? btb_target[f_idx] : pc_plus4;

   assign e_idx = ex_pc[IDX_W+1:2];
   assign e_tag = ex_pc[XLEN-1:IDX_W+2];
   assign e_hit = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
   assign upd = ex_valid && ex_is_cf;

   assign redirect = upd && ((ex_pred_taken != ex_taken) ||
                     (ex_taken && (ex_pred_target != ex_target)));
   assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

   // Redirect wins over a stall so a flushed path never lingers
   always_comb begin
      pc_next = pc_plus4;
      if (redirect) pc_next = redirect_pc;
      else if (stall_f) pc_next = pc_f;
      else if (pred_taken_f) pc_next = pred_target_f;
   end

   assign imem_addr = pc_next[IADDR_W+1:2];

   always_comb begin
      ctr_new = btb_ctr[e_idx];
      if (ex_taken && (ctr_new != 2'b11)) ctr_new = ctr_new + 2'd1;
      else if (!ex_taken && (ctr_new != 2'b00)) ctr_new = ctr_new - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_f <= RESET_PC;
         btb_valid <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) btb_ctr[i] <= 2'b01;
         branch_cnt <= '0;
         mispred_cnt <= '0;
      end else begin
         pc_f <= pc_next;
         if (upd) begin
            branch_cnt <= branch_cnt + CNT_W'(1);
            if (e_hit) begin
               btb_ctr[e_idx] <= ctr_new;
            end else if (ex_taken) begin
               btb_valid[e_idx] <= 1'b1;
               btb_ctr[e_idx] <= 2'b10;
            end
         end
         if (redirect) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end

   // Tag/target need no reset: valid gates every use
   always_ff @(posedge clk) begin
      if (!rst && upd && ex_taken) begin
         btb_tag[e_idx] <= e_tag;
         btb_target[e_idx] <= ex_target;
      end
   end

endmodule

// File: tb/tb_fetch_btb_unit.sv
// Bench for fetch_btb_unit: vector table through a scoreboard queue,
// then hand sequences for counter saturation and target mispredicts.
module tb_fetch_btb_unit;

   logic clk = 1'b0;
   logic rst;
   logic stall_f;
   logic ex_valid;
   logic ex_is_cf;
   logic [31:0] ex_pc;
   logic ex_taken;
   logic [31:0] ex_target;
   logic ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic [31:0] pc_f;
   logic [31:0] pc_next;
   logic [5:0] imem_addr;
   logic pred_taken_f;
   logic [31:0] pred_target_f;
   logic redirect;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_btb_unit dut (
      .clk(clk),
      .rst(rst),
      .stall_f(stall_f),
      .ex_valid(ex_valid),
      .ex_is_cf(ex_is_cf),
      .ex_pc(ex_pc),
      .ex_taken(ex_taken),
      .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target),
      .pc_f(pc_f),
      .pc_next(pc_next),
      .imem_addr(imem_addr),
      .pred_taken_f(pred_taken_f),
      .pred_target_f(pred_target_f),
      .redirect(redirect),
      .branch_cnt(branch_cnt),
      .mispred_cnt(mispred_cnt)
   );

   typedef struct {
      logic rst, stall, v, cf, tk, ppt;
      logic [31:0] epc, tgt, pptg;
      logic [31:0] pc, nxt, ptg, bc, mc;
      logic pt, rd;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   function automatic vec_t mk(
      input logic r, input logic s, input logic v, input logic cf,
      input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
      input logic ppt, input logic [31:0] pptg,
      input logic [31:0] pc, input logic [31:0] nxt, input logic pt,
      input logic [31:0] ptg, input logic rd,
      input logic [31:0] bc, input logic [31:0] mc);
      vec_t e;
      e.rst = r; e.stall = s; e.v = v; e.cf = cf;
      e.epc = epc; e.tk = tk; e.tgt = tgt;
      e.ppt = ppt; e.pptg = pptg;
      e.pc = pc; e.nxt = nxt; e.pt = pt; e.ptg = ptg;
      e.rd = rd; e.bc = bc; e.mc = mc;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      stall_f = 1'b0; ex_valid = 1'b0; ex_is_cf = 1'b0;
      ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
      ex_pred_taken = 1'b0; ex_pred_target = '0;
   endtask

   task automatic drive_ex(input logic [31:0] p, input logic t,
                           input logic [31:0] g, input logic pp,
                           input logic [31:0] pg);
      ex_valid = 1'b1; ex_is_cf = 1'b1; ex_pc = p;
      ex_taken = t; ex_target = g;
      ex_pred_taken = pp; ex_pred_target = pg;
   endtask

   task automatic resolve(input logic [31:0] p, input logic t,
                          input logic [31:0] g);
      drive_ex(p, t, g, t, g);
      @(posedge clk); #1;
      idle();
   endtask

   // Redirect fetch to p via a not-taken mispredict at p-4, then inspect
   task automatic probe(input string nm, input logic [31:0] p,
                        input logic ept, input logic [31:0] etg);
      drive_ex(p - 32'd4, 1'b0, 32'd0, 1'b1, 32'd0);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      chk({nm, " pc_f"}, pc_f, p);
      chk({nm, " pred_taken_f"}, {31'd0, pred_taken_f}, {31'd0, ept});
      chk({nm, " pred_target_f"}, pred_target_f, etg);
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t e;
      logic [31:0] n;
      // rst stl v cf epc tk tgt ppt pptg | pc nxt pt ptg rd bc mc
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h0,32'h4,0,32'h4,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h4,32'h8,0,32'h8,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h8,32'hC,0,32'hC,0,0,0));
      vecs.push_back(mk(0,0,1,0,32'h10,1,32'h40,0,0,
                        32'hC,32'h10,0,32'h10,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h10,32'h14,0,32'h14,0,0,0));
      vecs.push_back(mk(0,0,1,1,32'h10,1,32'h40,0,32'h14,
                        32'h14,32'h40,0,32'h18,1,0,0));
      vecs.push_back(mk(0,0,1,1,32'hC,0,0,1,32'h20,
                        32'h40,32'h10,0,32'h44,1,1,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h10,32'h40,1,32'h40,0,2,2));
      vecs.push_back(mk(0,0,1,1,32'h10,1,32'h40,1,32'h40,
                        32'h40,32'h44,0,32'h44,0,2,2));
      vecs.push_back(mk(0,0,1,1,32'h10,0,0,1,32'h40,
                        32'h44,32'h14,0,32'h48,1,3,2));
      vecs.push_back(mk(0,0,1,1,32'h10,0,0,0,32'h14,
                        32'h14,32'h18,0,32'h18,0,4,3));
      vecs.push_back(mk(0,0,1,1,32'hC,0,0,1,32'h20,
                        32'h18,32'h10,0,32'h1C,1,5,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h10,32'h14,0,32'h40,0,6,4));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0,1,0,0,0,0,0,0,0,
                           32'h14,32'h14,0,32'h18,0,6,4));
      vecs.push_back(mk(0,1,1,1,32'hC,0,0,1,32'h20,
                        32'h14,32'h10,0,32'h18,1,6,4));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h10,32'h14,0,32'h40,0,7,5));
      vecs.push_back(mk(0,0,1,1,32'h10,1,32'h40,0,32'h14,
                        32'h14,32'h40,0,32'h18,1,7,5));
      vecs.push_back(mk(0,0,1,1,32'h4C,0,0,1,32'h60,
                        32'h40,32'h50,0,32'h44,1,8,6));
      vecs.push_back(mk(0,0,1,1,32'h50,1,32'h80,0,32'h54,
                        32'h50,32'h80,0,32'h54,1,9,7));
      vecs.push_back(mk(0,0,1,1,32'h4C,0,0,1,32'h60,
                        32'h80,32'h50,0,32'h84,1,10,8));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h50,32'h80,1,32'h80,0,11,9));
      vecs.push_back(mk(0,0,1,1,32'hC,0,0,1,32'h20,
                        32'h80,32'h10,0,32'h84,1,11,9));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h10,32'h14,0,32'h14,0,12,10));
      vecs.push_back(mk(1,0,1,1,32'h50,1,32'h90,0,32'h54,
                        32'h14,32'h90,0,32'h18,1,12,10));
      vecs.push_back(mk(0,0,1,1,32'h4C,0,0,1,32'h60,
                        32'h0,32'h50,0,32'h4,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h50,32'h54,0,32'h54,0,1,1));
      vecs.push_back(mk(0,0,1,1,32'hC,0,0,1,32'h20,
                        32'h54,32'h10,0,32'h58,1,1,1));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h10,32'h14,0,32'h14,0,2,2));
      vecs.push_back(mk(0,0,1,1,32'hFFFFFFF8,0,0,1,0,
                        32'h14,32'hFFFFFFFC,0,32'h18,1,2,2));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,0,
                        32'hFFFFFFFC,32'h0,0,32'h0,0,3,3));

      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst;
         stall_f = vecs[i].stall;
         ex_valid = vecs[i].v;
         ex_is_cf = vecs[i].cf;
         ex_pc = vecs[i].epc;
         ex_taken = vecs[i].tk;
         ex_target = vecs[i].tgt;
         ex_pred_taken = vecs[i].ppt;
         ex_pred_target = vecs[i].pptg;
         sb.push_back(vecs[i]);
         @(negedge clk);
         e = sb.pop_front();
         n = e.nxt;
         chk($sformatf("v%0d pc_f", i), pc_f, e.pc);
         chk($sformatf("v%0d pc_next", i), pc_next, e.nxt);
         chk($sformatf("v%0d imem_addr", i), {26'd0, imem_addr},
             {26'd0, n[7:2]});
         chk($sformatf("v%0d pred_taken_f", i), {31'd0, pred_taken_f},
             {31'd0, e.pt});
         chk($sformatf("v%0d pred_target_f", i), pred_target_f, e.ptg);
         chk($sformatf("v%0d redirect", i), {31'd0, redirect},
             {31'd0, e.rd});
         chk($sformatf("v%0d branch_cnt", i), branch_cnt, e.bc);
         chk($sformatf("v%0d mispred_cnt", i), mispred_cnt, e.mc);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      idle();

      // Saturation at 11: three taken from 10 then one not-taken
      resolve(32'h20, 1'b1, 32'h60);
      resolve(32'h20, 1'b1, 32'h60);
      resolve(32'h20, 1'b1, 32'h60);
      probe("sat11", 32'h20, 1'b1, 32'h60);
      resolve(32'h20, 1'b0, 32'h0);
      probe("dec10", 32'h20, 1'b1, 32'h60);
      resolve(32'h20, 1'b0, 32'h0);
      probe("dec01", 32'h20, 1'b0, 32'h60);
      // Saturation at 00: extra not-taken then a single taken
      resolve(32'h20, 1'b0, 32'h0);
      resolve(32'h20, 1'b0, 32'h0);
      resolve(32'h20, 1'b0, 32'h0);
      resolve(32'h20, 1'b1, 32'h60);
      probe("sat00", 32'h20, 1'b0, 32'h60);

      // Right direction, wrong target
      drive_ex(32'h20, 1'b1, 32'h64, 1'b1, 32'h60);
      @(negedge clk);
      chk("wrong_tgt redirect", {31'd0, redirect}, 32'd1);
      chk("wrong_tgt pc_next", pc_next, 32'h64);
      @(posedge clk); #1;
      idle();
      chk("wrong_tgt pc_f", pc_f, 32'h64);
      probe("new_tgt", 32'h20, 1'b1, 32'h64);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
